// File: rtl/sn_operand_deserializer.sv
// Two-lane serial operand receiver for a stochastic-number datapath.
// Completed A/B pairs wait in pending registers and are committed only on an epoch boundary.
module sn_operand_deserializer #(
    parameter int DATA_W   = 9,
    parameter int CLAMP_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_a,
    input  logic              ser_b,
    input  logic              epoch_start,
    input  logic              err_clr,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] op_a_clamped,
    output logic              op_valid,
    output logic              pend_full,
    output logic [1:0]        frame_err
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } lane_state_e;

    localparam logic [3:0]        LAST_BIT = 4'(DATA_W - 1);
    localparam logic [DATA_W-1:0] CLAMP_LO = DATA_W'(9'h0F1);
    localparam logic [DATA_W-1:0] CLAMP_HI = DATA_W'(9'h10F);

    lane_state_e       state_q [2];
    logic [3:0]        cnt_q   [2];
    logic [DATA_W-1:0] shift_q [2];
    logic [DATA_W-1:0] pend_q  [2];

    logic [1:0]        ser_w;
    logic [1:0]        good_w;
    logic [1:0]        bad_w;
    logic [1:0]        done_q;
    logic [1:0]        done_d;
    logic [1:0]        err_q;
    logic [1:0]        err_d;
    logic              pend_full_q;
    logic              pend_full_d;
    logic              op_valid_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic              commit_w;

    assign ser_w    = {ser_b, ser_a};
    assign commit_w = epoch_start & pend_full_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign good_w[gi] = (state_q[gi] == S_STOP) & ~ser_w[gi];
            assign bad_w[gi]  = (state_q[gi] == S_STOP) &  ser_w[gi];
            // A frame finishing on the commit cycle re-arms its lane after the old pair leaves.
            assign done_d[gi] = good_w[gi] | (done_q[gi] & ~commit_w);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q[gi] <= S_IDLE;
                    cnt_q[gi]   <= '0;
                    shift_q[gi] <= '0;
                    pend_q[gi]  <= '0;
                end else begin
                    case (state_q[gi])
                        S_IDLE: begin
                            if (ser_w[gi]) begin
                                state_q[gi] <= S_DATA;
                                cnt_q[gi]   <= '0;
                            end
                        end
                        S_DATA: begin
                            shift_q[gi] <= {ser_w[gi], shift_q[gi][DATA_W-1:1]};
                            cnt_q[gi]   <= cnt_q[gi] + 4'd1;
                            if (cnt_q[gi] == LAST_BIT) begin
                                state_q[gi] <= S_STOP;
                            end
                        end
                        S_STOP: begin
                            if (good_w[gi]) begin
                                pend_q[gi] <= shift_q[gi];
                            end
                            state_q[gi] <= S_IDLE;
                        end
                        default: state_q[gi] <= S_IDLE;
                    endcase
                end
            end
        end
    endgenerate

    // A new stop-bit error beats a simultaneous clear.
    assign err_d       = (err_clr ? 2'b00 : err_q) | bad_w;
    assign pend_full_d = &done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= '0;
            pend_full_q <= 1'b0;
            err_q       <= '0;
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            done_q      <= done_d;
            pend_full_q <= pend_full_d;
            err_q       <= err_d;
            if (commit_w) begin
                op_a_q     <= pend_q[0];
                op_b_q     <= pend_q[1];
                op_valid_q <= 1'b1;
            end
        end
    end

    generate
        if (CLAMP_EN != 0) begin : g_clamp
            always_comb begin
                op_a_clamped = op_a_q;
                if (op_a_q > CLAMP_HI) begin
                    op_a_clamped = CLAMP_HI;
                end else if (op_a_q < CLAMP_LO) begin
                    op_a_clamped = CLAMP_LO;
                end
            end
        end else begin : g_no_clamp
            assign op_a_clamped = op_a_q;
        end
    endgenerate

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_valid  = op_valid_q;
    assign pend_full = pend_full_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_sn_operand_deserializer.sv
// Scoreboard bench: per-cycle stimulus schedule drives a frame-level model, a monitor
// pops one expected output record per clock and compares it with the DUT.
module tb_sn_operand_deserializer;
    localparam int W = 9;

    logic         clk;
    logic         rst_n;
    logic         ser_a;
    logic         ser_b;
    logic         epoch_start;
    logic         err_clr;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] op_a_clamped;
    logic         op_valid;
    logic         pend_full;
    logic [1:0]   frame_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic a, b, ep, clr, a_end, b_end, a_good, b_good;
        logic [W-1:0] a_val, b_val;
    } cyc_t;

    typedef struct {
        logic [W-1:0] a, b, cl;
        logic v, pf;
        logic [1:0] err;
    } exp_t;

    cyc_t sched[$];
    exp_t exp_q[$];

    logic [W-1:0] m_pend [2];
    logic [1:0]   m_done;
    logic [1:0]   m_err;
    logic [W-1:0] m_opa;
    logic [W-1:0] m_opb;
    logic         m_valid;

    sn_operand_deserializer #(.DATA_W(W), .CLAMP_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .ser_a(ser_a), .ser_b(ser_b),
        .epoch_start(epoch_start), .err_clr(err_clr),
        .op_a(op_a), .op_b(op_b), .op_a_clamped(op_a_clamped),
        .op_valid(op_valid), .pend_full(pend_full), .frame_err(frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] clamp_ref(input logic [W-1:0] x);
        if (x > 9'h10F) return 9'h10F;
        if (x < 9'h0F1) return 9'h0F1;
        return x;
    endfunction

    function automatic exp_t mk_exp();
        exp_t e;
        e.a = m_opa; e.b = m_opb; e.cl = clamp_ref(m_opa);
        e.v = m_valid; e.pf = &m_done; e.err = m_err;
        return e;
    endfunction

    function automatic void model_reset();
        m_pend[0] = '0; m_pend[1] = '0;
        m_done = '0; m_err = '0;
        m_opa = '0; m_opb = '0; m_valid = 1'b0;
    endfunction

    // Frame-level rules: commit old pair first, then clear, then land new frames.
    function automatic void model_step(input cyc_t c);
        if (c.ep && (&m_done)) begin
            m_opa = m_pend[0]; m_opb = m_pend[1]; m_valid = 1'b1; m_done = '0;
        end
        if (c.clr) m_err = '0;
        if (c.a_end) begin
            if (c.a_good) begin m_pend[0] = c.a_val; m_done[0] = 1'b1; end
            else m_err[0] = 1'b1;
        end
        if (c.b_end) begin
            if (c.b_good) begin m_pend[1] = c.b_val; m_done[1] = 1'b1; end
            else m_err[1] = 1'b1;
        end
    endfunction

    function automatic void ensure(input int n);
        cyc_t z;
        z = '{default: 0};
        while (sched.size() < n) sched.push_back(z);
    endfunction

    function automatic void put(input int lane, input int idx, input logic v);
        cyc_t c;
        ensure(idx + 1);
        c = sched[idx];
        if (lane == 0) c.a = v; else c.b = v;
        sched[idx] = c;
    endfunction

    function automatic void add_frame(input int lane, input int start,
                                      input logic [W-1:0] val, input logic good);
        cyc_t c;
        int   last;
        last = start + W + 1;
        put(lane, start, 1'b1);
        for (int i = 0; i < W; i++) put(lane, start + 1 + i, val[i]);
        put(lane, last, ~good);
        c = sched[last];
        if (lane == 0) begin c.a_end = 1'b1; c.a_good = good; c.a_val = val; end
        else begin c.b_end = 1'b1; c.b_good = good; c.b_val = val; end
        sched[last] = c;
    endfunction

    function automatic void add_ep(input int idx);
        cyc_t c;
        ensure(idx + 1);
        c = sched[idx]; c.ep = 1'b1; sched[idx] = c;
    endfunction

    function automatic void add_clr(input int idx);
        cyc_t c;
        ensure(idx + 1);
        c = sched[idx]; c.clr = 1'b1; sched[idx] = c;
    endfunction

    task automatic run_sched();
        cyc_t c;
        int   k;
        ensure(sched.size() + 1);
        for (int i = 0; i < sched.size(); i++) begin
            c = sched[i];
            @(negedge clk);
            ser_a = c.a; ser_b = c.b; epoch_start = c.ep; err_clr = c.clr;
            model_step(c);
            exp_q.push_back(mk_exp());
        end
        sched.delete();
        k = 0;
        while (exp_q.size() > 0 && k < 8) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain: got %0d pending records, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_direct(input string name);
        exp_t e;
        e = mk_exp();
        tests++;
        if (op_a !== e.a || op_b !== e.b || op_a_clamped !== e.cl || op_valid !== e.v ||
            pend_full !== e.pf || frame_err !== e.err) begin
            fails++;
            $display("FAIL %s: got a=%h b=%h cl=%h v=%b pf=%b err=%b, required a=%h b=%h cl=%h v=%b pf=%b err=%b",
                     name, op_a, op_b, op_a_clamped, op_valid, pend_full, frame_err,
                     e.a, e.b, e.cl, e.v, e.pf, e.err);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (op_a !== e.a || op_b !== e.b || op_a_clamped !== e.cl || op_valid !== e.v ||
                    pend_full !== e.pf || frame_err !== e.err) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t: got a=%h b=%h cl=%h v=%b pf=%b err=%b, required a=%h b=%h cl=%h v=%b pf=%b err=%b",
                             $time, op_a, op_b, op_a_clamped, op_valid, pend_full, frame_err,
                             e.a, e.b, e.cl, e.v, e.pf, e.err);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; ser_a = 1'b0; ser_b = 1'b0; epoch_start = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_direct("reset_state");
        rst_n = 1'b1;

        // Basic pair then commit.
        add_frame(0, 1, 9'h155, 1'b1); add_frame(1, 1, 9'h0AA, 1'b1); add_ep(13);
        run_sched();

        // Stops coincide with epoch: old pair 011/022 commits, new pair lands pending.
        add_frame(0, 1, 9'h011, 1'b1); add_frame(1, 1, 9'h022, 1'b1);
        run_sched();
        add_frame(0, 1, 9'h1FF, 1'b1); add_frame(1, 1, 9'h000, 1'b1); add_ep(W + 1);
        run_sched();
        add_ep(1);
        run_sched();

        // Clamp low and in-range values.
        add_frame(0, 1, 9'h000, 1'b1); add_frame(1, 1, 9'h155, 1'b1); add_ep(W + 3);
        run_sched();
        add_frame(0, 1, 9'h100, 1'b1); add_frame(1, 1, 9'h001, 1'b1); add_ep(W + 3);
        run_sched();

        // Stop-bit errors, clear, and clear colliding with a new error.
        add_frame(0, 1, 9'h0F0, 1'b0);
        run_sched();
        add_clr(1);
        run_sched();
        add_frame(0, 1, 9'h033, 1'b0); add_clr(W + 1);
        run_sched();
        add_clr(1);
        run_sched();

        // Only lane A completes: epoch must not commit.
        add_frame(0, 1, 9'h0AB, 1'b1); add_ep(W + 4);
        run_sched();

        // Reset in the middle of a frame pair.
        add_frame(0, 1, 9'h1C3, 1'b1); add_frame(1, 1, 9'h05A, 1'b1);
        while (sched.size() > 7) void'(sched.pop_back());
        run_sched();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        ser_a = 1'b0; ser_b = 1'b0; epoch_start = 1'b0; err_clr = 1'b0;
        model_reset();
        #1;
        check_direct("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        add_frame(0, 2, 9'h0C3, 1'b1); add_frame(1, 2, 9'h13C, 1'b1); add_ep(W + 5);
        run_sched();

        // Randomized frames, offsets, stop errors, epochs and clears.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 99) < 85)
                add_frame(0, 1 + int'($urandom_range(0, 3)), W'($urandom_range(0, 511)),
                          logic'($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 99) < 85)
                add_frame(1, 1 + int'($urandom_range(0, 3)), W'($urandom_range(0, 511)),
                          logic'($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 1) == 1) add_ep(int'($urandom_range(0, W + 8)));
            if ($urandom_range(0, 9) == 0) add_clr(int'($urandom_range(0, W + 6)));
            run_sched();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sn_operand_deserializer.md
SN_OPERAND_DESERIALIZER -- requirements
Module: sn_operand_deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 9, operand width in bits.
REQ-002 SHALL have parameter CLAMP_EN, default 1; 1 enables the self-multiplier clamp on op_a_clamped.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ser_a  input  1  serial frame line, operand A.
REQ-006 ser_b  input  1  serial frame line, operand B.
REQ-007 epoch_start  input  1  one-cycle pulse marking the start of a new stochastic accumulation epoch.
REQ-008 op_a  output  DATA_W  active operand A, fed to SN generators.
REQ-009 op_b  output  DATA_W  active operand B.
REQ-010 op_a_clamped  output  DATA_W  op_a limited to [0x0F1, 0x10F] when CLAMP_EN=1; equals op_a otherwise.
REQ-011 op_valid  output  1  high once the first operand pair has been committed.
REQ-012 pend_full  output  1  a complete new operand pair is waiting for the next epoch.
REQ-013 frame_err  output  2  sticky per-lane stop-bit error flags; bit0 = A, bit1 = B.
REQ-014 err_clr  input  1  synchronous clear of frame_err.

Function
REQ-015 Frame per lane SHALL be: idle 0; start bit 1; DATA_W data bits, LSB first; stop bit 0. One bit per clk.
REQ-016 Each lane SHALL run an independent FSM: IDLE -> DATA on ser=1; DATA -> STOP after DATA_W bits (4-bit bit counter); STOP -> IDLE always.
REQ-017 In STOP, ser=0 SHALL latch the lane's shift register into its lane-pending register and set lane_done. ser=1 SHALL discard the data and set the lane's frame_err bit.
REQ-018 pend_full SHALL assert in the cycle after both lane_done flags are set, and SHALL stay high until consumed.
REQ-019 While pend_full=1, a newer good frame on a lane SHALL overwrite that lane's pending value; the last good frame wins.
REQ-020 On epoch_start with pend_full=1: next cycle op_a/op_b <= pending values, op_valid <= 1, pend_full <= 0, both lane_done <= 0.
REQ-021 On epoch_start with pend_full=0: op_a/op_b/op_valid SHALL be unchanged.
REQ-022 Operands SHALL only change on epoch boundaries; they are stable for the whole epoch.
REQ-023 If a frame completes in the same cycle as epoch_start, the epoch SHALL commit the prior pending pair, and the new frame SHALL land in pending with lane_done set.
REQ-024 If only one lane completes, the pair SHALL stay incomplete and nothing SHALL be committed.
REQ-025 op_a_clamped SHALL be combinational from op_a: >0x10F -> 0x10F; <0x0F1 -> 0x0F1; else op_a.
REQ-026 If err_clr and a new error occur in the same cycle, the error SHALL win and the bit stays set.
REQ-027 Latency: stop-bit cycle to pend_full = 1 clk; epoch_start to op_* update = 1 clk.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: FSMs IDLE, bit counters 0, shift/pending regs 0, lane_done 0, op_a=op_b=0, op_valid=0, pend_full=0, frame_err=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; after release, a lane SHALL accept only a fresh start bit.
REQ-030 The first rising edge after rst_n deasserts SHALL behave as a normal cycle with no spurious commit.

Verification
REQ-031 Frames A=0x155, B=0x0AA with good stops, then epoch_start -> pend_full=1 one cycle after the stops; next cycle after epoch_start, op_a=0x155, op_b=0x0AA, op_valid=1, pend_full=0.
REQ-032 A=0x1FF committed -> op_a_clamped=0x10F; A=0x000 -> 0x0F1; A=0x100 -> 0x100.
REQ-033 Frame A with stop=1 -> frame_err=2'b01, no lane_done; err_clr pulse -> 2'b00; err_clr coincident with a new error -> 2'b01.
REQ-034 Both frames' stop bits in the same cycle as epoch_start, with previous pending 0x011/0x022 -> ops become 0x011/0x022, pend_full re-asserts with the new values.
REQ-035 rst_n low at bit 5 of frame A, released, then a full A/B pair -> only the post-reset values reach pending, frame_err=0.
REQ-036 Only lane A completes, then epoch_start -> op_a/op_b unchanged, op_valid unchanged, pend_full=0.
